// File: rtl/crc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc_seq_ctrl
// Description : Request/response sequencer for a byte-wide CRC-32
//               table-lookup datapath. It holds the running 32-bit CRC
//               state and splits each UPDATE into 1-4 serial byte lookups
//               against an external 256x32 CRC ROM.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op              00 INIT, 01 UPDATE, 10 READ, 11 reserved
//   req_len             UPDATE byte count, 0 encodes 4 bytes
//   req_data            INIT seed or UPDATE bytes (bits [7:0] first)
//   resp_valid/ready    response handshake
//   resp_data           response payload
//   resp_err            set for the reserved opcode
//   rom_index           ROM address (0 when no lookup is in flight)
//   rom_data            ROM word, valid ROM_LAT cycles after rom_index
//
// Parameters
//   ROM_LAT       0 = combinational ROM, 1 = registered ROM; others rejected
//   SEED_DEFAULT  CRC state loaded by reset
//
// Build option
//   CRC_SEQ_FINAL_XOR_EN  when defined, READ and UPDATE responses return the
//                         complemented state; INIT echo and state untouched.
//
// Revision    : 1.0  initial release
// ============================================================================
module crc_seq_ctrl #(
  parameter int          ROM_LAT      = 1,
  parameter logic [31:0] SEED_DEFAULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [7:0]  rom_index,
  input  logic [31:0] rom_data
);

  // --------------------------------------------------------------------------
  // Elaboration guard: only the two supported ROM latencies may be built.
  // --------------------------------------------------------------------------
  generate
    if ((ROM_LAT != 0) && (ROM_LAT != 1)) begin : g_bad_rom_lat
      $error("crc_seq_ctrl: ROM_LAT must be 0 or 1");
    end
  endgenerate

  // Opcodes
  localparam logic [1:0] c_OP_INIT   = 2'b00;
  localparam logic [1:0] c_OP_UPDATE = 2'b01;
  localparam logic [1:0] c_OP_READ   = 2'b10;

  // Mask applied to the state when it is reported on READ/UPDATE responses.
`ifdef CRC_SEQ_FINAL_XOR_EN
  localparam logic [31:0] c_OUT_XOR = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] c_OUT_XOR = 32'h0000_0000;
`endif

  // A combinational ROM lets LOOKUP consume rom_data in the same cycle.
  localparam bit c_COMB_ROM = (ROM_LAT == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [31:0] r_sh;
  logic [2:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_busy;
  logic        w_last;
  logic        w_step;
  logic [7:0]  w_index;
  logic [31:0] w_crc_next;

  // r_req_ready is only ever set while in IDLE, so it alone qualifies accept.
  assign w_accept   = req_valid & r_req_ready;
  assign w_busy     = (r_state == S_LOOKUP) || (r_state == S_WAIT);
  assign w_last     = (r_cnt == 3'd1);

  // The cycle in which rom_data is consumed for the current byte.
  assign w_step     = ((r_state == S_LOOKUP) && c_COMB_ROM) || (r_state == S_WAIT);

  // crc and sh only change on a step, so the index stays stable from LOOKUP
  // through WAIT as a registered ROM requires.
  assign w_index    = r_crc[7:0] ^ r_sh[7:0];
  assign w_crc_next = rom_data ^ {8'h00, r_crc[31:8]};

  assign rom_index  = w_busy ? w_index : 8'h00;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_crc        <= SEED_DEFAULT;
      r_sh         <= 32'h0000_0000;
      r_cnt        <= 3'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Ready rises one cycle after reset release and stays up until
          // a command is taken.
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            case (req_op)
              c_OP_INIT: begin
                r_crc        <= req_data;
                r_resp_data  <= req_data;
                r_resp_err   <= 1'b0;
                r_resp_valid <= 1'b1;
                r_state      <= S_RESP;
              end
              c_OP_UPDATE: begin
                r_sh    <= req_data;
                r_cnt   <= (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
                r_state <= S_LOOKUP;
              end
              c_OP_READ: begin
                r_resp_data  <= r_crc ^ c_OUT_XOR;
                r_resp_err   <= 1'b0;
                r_resp_valid <= 1'b1;
                r_state      <= S_RESP;
              end
              default: begin
                r_resp_data  <= 32'h0000_0000;
                r_resp_err   <= 1'b1;
                r_resp_valid <= 1'b1;
                r_state      <= S_RESP;
              end
            endcase
          end
        end

        S_LOOKUP, S_WAIT: begin
          if (w_step) begin
            r_crc <= w_crc_next;
            r_sh  <= {8'h00, r_sh[31:8]};
            r_cnt <= r_cnt - 3'd1;
            if (w_last) begin
              // Response reports the state after the final byte.
              r_resp_data  <= w_crc_next ^ c_OUT_XOR;
              r_resp_err   <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_LOOKUP;
            end
          end else begin
            // Registered ROM: address was presented this cycle, data next.
            r_state <= S_WAIT;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/crc_seq_ctrl.md
Name: crc_seq_ctrl

Overview:
- Request/response sequencer for the byte-wide CRC-32 table-lookup datapath used by the CFU.
- Accepts INIT, UPDATE and READ commands over a valid/ready request channel and holds the running 32-bit CRC state.
- An UPDATE is split into 1-4 serial byte lookups against an external 256x32 CRC ROM, one byte per lookup.
- The result is returned on a valid/ready response channel.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles. 0 means a combinational ROM; 1 means a registered/BRAM ROM. Other values are illegal and must fail elaboration.
- SEED_DEFAULT, 32'hFFFFFFFF, CRC state value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  2  00 INIT, 01 UPDATE, 10 READ, 11 reserved
- req_len  in  2  UPDATE byte count; 0 means 4 bytes
- req_data  in  32  INIT seed, or UPDATE bytes (byte0 = [7:0] processed first)
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_data  out  32  response payload
- resp_err  out  1  reserved opcode flag
- rom_index  out  8  ROM address
- rom_data  in  32  ROM word, valid ROM_LAT cycles after rom_index

Behaviour:
- Reset is synchronous: state <= IDLE, crc <= SEED_DEFAULT, resp_valid=0, resp_err=0, resp_data=0, req_ready=0 on the reset cycle, rom_index=0.
- Reset asserted mid-operation aborts any UPDATE in progress and drops any pending response.
- States:
  - IDLE: req_ready=1.
  - LOOKUP: issue one byte.
  - WAIT: present only when ROM_LAT=1.
  - RESP: hold the response.
- IDLE on accept:
  - INIT: crc <= req_data, go to RESP with resp_data = req_data.
  - READ: go to RESP with resp_data = crc_out (see Optional Feature).
  - UPDATE: latch data into shift register sh; cnt <= (req_len==0 ? 4 : req_len); go to LOOKUP.
  - op 11: go to RESP with resp_err=1, resp_data=0; crc unchanged.
- LOOKUP: rom_index = crc[7:0] ^ sh[7:0].
  - ROM_LAT=0: same cycle, crc <= rom_data ^ (crc >> 8) (logical shift, zero fill); sh <= sh >> 8; cnt <= cnt-1. If cnt==1, go to RESP, else stay.
  - ROM_LAT=1: go to WAIT; rom_index held stable.
- WAIT: apply the same update as the ROM_LAT=0 case using rom_data. If cnt==1, go to RESP, else return to LOOKUP.
- UPDATE latency from accept to resp_valid:
  - ROM_LAT=0: N+1 cycles.
  - ROM_LAT=1: 2N+1 cycles.
  - N = byte count.
- UPDATE response: resp_data = crc_out after the final byte.
- RESP: resp_valid=1, resp_data/resp_err stable until resp_ready.
  - On handshake: resp_valid<=0, resp_err<=0, go to IDLE.
  - req_ready=0 throughout.
  - resp_ready held high gives back-to-back ops with 1 idle/accept cycle between responses.
- req_ready is 0 in every state except IDLE; at most one command is outstanding.
- resp_valid is registered, not combinational from req_valid.
- Signals of a request not accepted are ignored.
- rom_index is 0 outside LOOKUP/WAIT.

Optional Feature:
- Macro: CRC_SEQ_FINAL_XOR_EN.
- Defined: crc_out = crc ^ 32'hFFFFFFFF on READ and UPDATE responses. INIT response and internal state are unaffected.
- Undefined: crc_out = crc (raw state).

Test Plan:
- Reset, then READ -> raw resp_data 32'hFFFFFFFF (32'h00000000 with XOR_EN); resp_err=0.
- INIT 32'hFFFFFFFF; UPDATE len=1 data 32'h00 -> raw 32'h2DFD1072, XOR_EN 32'hD202EF8D.
  - rom_index=8'hFF observed.
  - ROM_LAT=1 latency 3 cycles.
- INIT 32'hFFFFFFFF; UPDATE len=0 32'h34333231; UPDATE len=0 32'h38373635; UPDATE len=1 32'h00000039; READ:
  - Raw 32'h340BC6D9; XOR_EN 32'hCBF43926.
  - Run for ROM_LAT=0 and ROM_LAT=1.
- Backpressure: hold resp_ready=0 for 5 cycles after UPDATE completes -> resp_valid, resp_data stable; req_ready=0; req_valid pulses ignored; crc unchanged.
- req_op=11 -> resp_err=1, resp_data=0; following READ returns the unchanged CRC.
- Assert rst during WAIT of a 4-byte UPDATE -> next cycle IDLE, resp_valid=0; READ returns SEED_DEFAULT-derived value.
